// File: rtl/icache_lookup_stage.sv
// Stage-1 instruction-cache lookup: tag/status arrays with masked writes,
// same-cycle write-to-read bypass, one-cycle read latency and a status-array flush sweep.
module icache_lookup_stage #(
    parameter int METADATA_WIDTH = 16,
    parameter int SET_BITS       = 4,
    parameter int NUM_WAYS       = 4,
    parameter int TAG_WIDTH      = 8,
    parameter int STATUS_WIDTH   = 2
) (
    input  logic                               clk,
    input  logic                               arst_n,
    input  logic                               i_halt,
    input  logic [METADATA_WIDTH-1:0]          i_metadata,
    input  logic                               i_metadata_valid,
    input  logic [SET_BITS-1:0]                i_r_set_addr,
    input  logic                               i_r_valid,
    input  logic [SET_BITS-1:0]                i_w_ta_set_addr,
    input  logic [TAG_WIDTH*NUM_WAYS-1:0]      i_w_ta_data,
    input  logic [NUM_WAYS-1:0]                i_w_ta_mask,
    input  logic                               i_w_ta_valid,
    input  logic [SET_BITS-1:0]                i_w_sa_set_addr,
    input  logic [STATUS_WIDTH*NUM_WAYS-1:0]   i_w_sa_data,
    input  logic [NUM_WAYS-1:0]                i_w_sa_mask,
    input  logic                               i_w_sa_valid,
    input  logic                               i_flush,
    output logic [TAG_WIDTH*NUM_WAYS-1:0]      o_ta_data,
    output logic                               o_ta_data_valid,
    output logic [STATUS_WIDTH*NUM_WAYS-1:0]   o_sa_data,
    output logic                               o_sa_data_valid,
    output logic [METADATA_WIDTH-1:0]          o_metadata,
    output logic                               o_metadata_valid,
    output logic                               o_flush_busy,
    output logic                               o_ready
);

    localparam int NUM_SETS = 2 ** SET_BITS;
    localparam int TA_W     = TAG_WIDTH * NUM_WAYS;
    localparam int SA_W     = STATUS_WIDTH * NUM_WAYS;
    localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(NUM_SETS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [SET_BITS-1:0] r_cnt;
    logic [SET_BITS-1:0] w_cnt_next;

    logic [TA_W-1:0] r_ta_mem [NUM_SETS];
    logic [SA_W-1:0] r_sa_mem [NUM_SETS];

    logic [TA_W-1:0]           r_ta_data;
    logic                      r_ta_data_valid;
    logic [SA_W-1:0]           r_sa_data;
    logic                      r_sa_data_valid;
    logic [METADATA_WIDTH-1:0] r_metadata;
    logic                      r_metadata_valid;

    logic            w_ready;
    logic            w_rd_acc;
    logic            w_ta_wr;
    logic            w_sa_wr;
    logic            w_flush_clr;
    logic [TA_W-1:0] w_ta_row;
    logic [SA_W-1:0] w_sa_row;

    // Every request input is qualified by this one signal; nothing is accepted while halted or flushing.
    assign w_ready     = ~i_halt & (r_state == ST_IDLE);
    assign w_rd_acc    = i_r_valid & w_ready;
    assign w_ta_wr     = i_w_ta_valid & w_ready;
    assign w_sa_wr     = i_w_sa_valid & w_ready;
    assign w_flush_clr = (r_state == ST_FLUSH) & ~i_halt;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state <= ST_FLUSH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_flush && w_ready) begin
                    w_state_next = ST_FLUSH;
                    w_cnt_next   = '0;
                end
            end
            ST_FLUSH: begin
                if (!i_halt) begin
                    if (r_cnt == LAST_SET) begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_FLUSH;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Tag array is never cleared; only fills from the miss path change it.
    always_ff @(posedge clk) begin
        if (arst_n && w_ta_wr) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (i_w_ta_mask[w]) begin
                    r_ta_mem[i_w_ta_set_addr][w*TAG_WIDTH +: TAG_WIDTH] <=
                        i_w_ta_data[w*TAG_WIDTH +: TAG_WIDTH];
                end
            end
        end
    end

    // Flush clears and host writes are exclusive: writes need IDLE, clears need FLUSH.
    always_ff @(posedge clk) begin
        if (arst_n) begin
            if (w_flush_clr) begin
                r_sa_mem[r_cnt] <= '0;
            end else if (w_sa_wr) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (i_w_sa_mask[w]) begin
                        r_sa_mem[i_w_sa_set_addr][w*STATUS_WIDTH +: STATUS_WIDTH] <=
                            i_w_sa_data[w*STATUS_WIDTH +: STATUS_WIDTH];
                    end
                end
            end
        end
    end

    always_comb begin
        w_ta_row = r_ta_mem[i_r_set_addr];
        w_sa_row = r_sa_mem[i_r_set_addr];
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (w_ta_wr && (i_w_ta_set_addr == i_r_set_addr) && i_w_ta_mask[w]) begin
                w_ta_row[w*TAG_WIDTH +: TAG_WIDTH] = i_w_ta_data[w*TAG_WIDTH +: TAG_WIDTH];
            end
            if (w_sa_wr && (i_w_sa_set_addr == i_r_set_addr) && i_w_sa_mask[w]) begin
                w_sa_row[w*STATUS_WIDTH +: STATUS_WIDTH] =
                    i_w_sa_data[w*STATUS_WIDTH +: STATUS_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_ta_data        <= '0;
            r_ta_data_valid  <= 1'b0;
            r_sa_data        <= '0;
            r_sa_data_valid  <= 1'b0;
            r_metadata       <= '0;
            r_metadata_valid <= 1'b0;
        end else if (!i_halt) begin
            r_ta_data_valid  <= w_rd_acc;
            r_sa_data_valid  <= w_rd_acc;
            r_metadata       <= i_metadata;
            r_metadata_valid <= i_metadata_valid & w_ready;
            if (w_rd_acc) begin
                r_ta_data <= w_ta_row;
                r_sa_data <= w_sa_row;
            end
        end
    end

    assign o_ta_data        = r_ta_data;
    assign o_ta_data_valid  = r_ta_data_valid;
    assign o_sa_data        = r_sa_data;
    assign o_sa_data_valid  = r_sa_data_valid;
    assign o_metadata       = r_metadata;
    assign o_metadata_valid = r_metadata_valid;
    assign o_flush_busy     = (r_state == ST_FLUSH);
    assign o_ready          = w_ready;

endmodule

// File: tb/tb_icache_lookup_stage.sv
// Directed bench for icache_lookup_stage: reset sweep, masked writes with bypass,
// halt freeze, halted flush and reset during a flush.
module tb_icache_lookup_stage;

    logic        clk;
    logic        arst_n;
    logic        i_halt;
    logic [15:0] i_metadata;
    logic        i_metadata_valid;
    logic [3:0]  i_r_set_addr;
    logic        i_r_valid;
    logic [3:0]  i_w_ta_set_addr;
    logic [31:0] i_w_ta_data;
    logic [3:0]  i_w_ta_mask;
    logic        i_w_ta_valid;
    logic [3:0]  i_w_sa_set_addr;
    logic [7:0]  i_w_sa_data;
    logic [3:0]  i_w_sa_mask;
    logic        i_w_sa_valid;
    logic        i_flush;
    logic [31:0] o_ta_data;
    logic        o_ta_data_valid;
    logic [7:0]  o_sa_data;
    logic        o_sa_data_valid;
    logic [15:0] o_metadata;
    logic        o_metadata_valid;
    logic        o_flush_busy;
    logic        o_ready;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int busy_cycles;
    int wait_cycles;

    icache_lookup_stage dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .i_halt           (i_halt),
        .i_metadata       (i_metadata),
        .i_metadata_valid (i_metadata_valid),
        .i_r_set_addr     (i_r_set_addr),
        .i_r_valid        (i_r_valid),
        .i_w_ta_set_addr  (i_w_ta_set_addr),
        .i_w_ta_data      (i_w_ta_data),
        .i_w_ta_mask      (i_w_ta_mask),
        .i_w_ta_valid     (i_w_ta_valid),
        .i_w_sa_set_addr  (i_w_sa_set_addr),
        .i_w_sa_data      (i_w_sa_data),
        .i_w_sa_mask      (i_w_sa_mask),
        .i_w_sa_valid     (i_w_sa_valid),
        .i_flush          (i_flush),
        .o_ta_data        (o_ta_data),
        .o_ta_data_valid  (o_ta_data_valid),
        .o_sa_data        (o_sa_data),
        .o_sa_data_valid  (o_sa_data_valid),
        .o_metadata       (o_metadata),
        .o_metadata_valid (o_metadata_valid),
        .o_flush_busy     (o_flush_busy),
        .o_ready          (o_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        arst_n = 1'b0; i_halt = 1'b0; i_metadata = '0; i_metadata_valid = 1'b0;
        i_r_set_addr = '0; i_r_valid = 1'b0;
        i_w_ta_set_addr = '0; i_w_ta_data = '0; i_w_ta_mask = '0; i_w_ta_valid = 1'b0;
        i_w_sa_set_addr = '0; i_w_sa_data = '0; i_w_sa_mask = '0; i_w_sa_valid = 1'b0;
        i_flush = 1'b0;

        // 1: reset, then a 16-cycle sweep, then status array reads as zero
        tick(); tick();
        check("rst_ta_valid", 64'(o_ta_data_valid), 64'd0);
        check("rst_sa_valid", 64'(o_sa_data_valid), 64'd0);
        check("rst_md_valid", 64'(o_metadata_valid), 64'd0);
        check("rst_ta_data", 64'(o_ta_data), 64'd0);
        check("rst_busy", 64'(o_flush_busy), 64'd1);
        check("rst_ready", 64'(o_ready), 64'd0);
        arst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("sweep_busy", 64'(o_flush_busy), 64'd1);
            check("sweep_ready", 64'(o_ready), 64'd0);
            tick();
        end
        check("sweep_done_busy", 64'(o_flush_busy), 64'd0);
        check("sweep_done_ready", 64'(o_ready), 64'd1);
        for (int s = 0; s < 16; s++) begin
            i_r_valid = 1'b1; i_r_set_addr = 4'(s);
            tick();
            check("init_sa_zero", 64'(o_sa_data), 64'h00);
            check("init_sa_valid", 64'(o_sa_data_valid), 64'd1);
        end
        i_r_valid = 1'b0;

        // 2: full-mask tag write then read one cycle later
        i_w_ta_valid = 1'b1; i_w_ta_set_addr = 4'd3; i_w_ta_data = 32'hA1B2C3D4; i_w_ta_mask = 4'hF;
        tick();
        i_w_ta_valid = 1'b0; i_r_valid = 1'b1; i_r_set_addr = 4'd3;
        tick();
        check("rd3_ta", 64'(o_ta_data), 64'hA1B2C3D4);
        check("rd3_valid", 64'(o_ta_data_valid), 64'd1);
        i_r_valid = 1'b0;
        tick();
        check("idle_valid_drop", 64'(o_ta_data_valid), 64'd0);
        check("idle_data_hold", 64'(o_ta_data), 64'hA1B2C3D4);

        // 3: masked write with same-cycle read of the same set
        i_w_ta_valid = 1'b1; i_w_ta_set_addr = 4'd5; i_w_ta_data = 32'h11223344; i_w_ta_mask = 4'hF;
        tick();
        i_w_ta_data = 32'hAABBCCDD; i_w_ta_mask = 4'b0101; i_r_valid = 1'b1; i_r_set_addr = 4'd5;
        tick();
        check("bypass_ta", 64'(o_ta_data), 64'h11BB33DD);
        i_w_ta_valid = 1'b0;
        tick();
        check("after_bypass_ta", 64'(o_ta_data), 64'h11BB33DD);
        i_w_sa_valid = 1'b1; i_w_sa_set_addr = 4'd5; i_w_sa_data = 8'hE4; i_w_sa_mask = 4'b0011;
        tick();
        check("bypass_sa", 64'(o_sa_data), 64'h04);
        check("bypass_sa_ta_row", 64'(o_ta_data), 64'h11BB33DD);
        i_w_sa_set_addr = 4'd7; i_w_sa_data = 8'h5A; i_w_sa_mask = 4'hF; i_r_valid = 1'b0;
        tick();
        i_w_sa_valid = 1'b0; i_r_valid = 1'b1; i_r_set_addr = 4'd7;
        tick();
        check("sa7_written", 64'(o_sa_data), 64'h5A);

        // 4: halt freezes outputs and blocks writes
        i_r_set_addr = 4'd3; i_metadata = 16'hBEEF; i_metadata_valid = 1'b1;
        tick();
        check("md_value", 64'(o_metadata), 64'hBEEF);
        check("md_valid", 64'(o_metadata_valid), 64'd1);
        check("md_ta", 64'(o_ta_data), 64'hA1B2C3D4);
        i_halt = 1'b1; i_metadata = 16'h1234; i_r_set_addr = 4'd5; i_flush = 1'b1;
        i_w_sa_valid = 1'b1; i_w_sa_set_addr = 4'd3; i_w_sa_data = 8'hFF; i_w_sa_mask = 4'hF;
        #1;
        check("halt_ready", 64'(o_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_md", 64'(o_metadata), 64'hBEEF);
            check("halt_md_valid", 64'(o_metadata_valid), 64'd1);
            check("halt_ta", 64'(o_ta_data), 64'hA1B2C3D4);
            check("halt_ta_valid", 64'(o_ta_data_valid), 64'd1);
            check("halt_busy", 64'(o_flush_busy), 64'd0);
        end
        i_halt = 1'b0; i_flush = 1'b0; i_w_sa_valid = 1'b0; i_metadata_valid = 1'b0;
        i_r_set_addr = 4'd3;
        tick();
        check("halt_sa_not_written", 64'(o_sa_data), 64'h00);
        check("post_halt_md", 64'(o_metadata), 64'h1234);
        check("post_halt_md_valid", 64'(o_metadata_valid), 64'd0);

        // 5: flush with a concurrent read, halted for 2 cycles mid-sweep
        i_flush = 1'b1; i_r_set_addr = 4'd3;
        tick();
        check("flush_start_ta", 64'(o_ta_data), 64'hA1B2C3D4);
        check("flush_start_valid", 64'(o_ta_data_valid), 64'd1);
        check("flush_start_busy", 64'(o_flush_busy), 64'd1);
        i_flush = 1'b0; i_r_valid = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!o_flush_busy) break;
            busy_cycles++;
            i_halt = (busy_cycles == 6 || busy_cycles == 7);
            tick();
        end
        i_halt = 1'b0;
        check("flush_busy_len", 64'(busy_cycles), 64'd18);
        check("flush_done_busy", 64'(o_flush_busy), 64'd0);
        i_r_valid = 1'b1; i_r_set_addr = 4'd7;
        tick();
        check("flush_sa7", 64'(o_sa_data), 64'h00);
        i_r_set_addr = 4'd5;
        tick();
        check("flush_sa5", 64'(o_sa_data), 64'h00);
        check("flush_ta5_intact", 64'(o_ta_data), 64'h11BB33DD);
        i_r_set_addr = 4'd3;
        tick();
        check("flush_ta3_intact", 64'(o_ta_data), 64'hA1B2C3D4);
        i_r_valid = 1'b0;

        // 6: reset at flush count 9 restarts a full 16-cycle sweep
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("mid_flush_busy", 64'(o_flush_busy), 64'd1);
        arst_n = 1'b0;
        tick();
        check("mid_rst_busy", 64'(o_flush_busy), 64'd1);
        check("mid_rst_ta_data", 64'(o_ta_data), 64'd0);
        check("mid_rst_ta_valid", 64'(o_ta_data_valid), 64'd0);
        arst_n = 1'b1;
        wait_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_ready) break;
            wait_cycles++;
            tick();
        end
        check("restart_len", 64'(wait_cycles), 64'd16);
        check("restart_ready", 64'(o_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
